duc_burst_ctrl: RTL and testbench

- Sequences one transmit burst through the digital upconverter (DUC).
- Per burst, in order:
  - programs the DDS phase increment over an AXI-stream config channel;
  - waits for the DDS output to settle;
  - streams baseband I/Q into the DUC, with a linear amplitude ramp-up and ramp-down at the burst edges;
  - flushes the DUC multiplier pipeline with zeros, then signals done.
- Sits between the modulator's I/Q stream and the DUC I_data/Q_data inputs, and drives the DDS config port.

---
 rtl/duc_burst_ctrl_if.sv | 23 ++
 rtl/duc_burst_ctrl.sv | 167 ++++++++++++++++
 tb/tb_duc_burst_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/duc_burst_ctrl_if.sv
// Streaming side of the DUC burst controller: DDS config channel plus the
// baseband I/Q path from the modulator into the DUC data inputs.
interface duc_burst_ctrl_if;
  logic        [31:0] cfg_tdata;
  logic               cfg_tvalid;
  logic               cfg_tready;
  logic               iq_tvalid;
  logic               iq_tready;
  logic signed [15:0] i_in;
  logic signed [15:0] q_in;
  logic signed [15:0] i_out;
  logic signed [15:0] q_out;

  modport master (
    output cfg_tdata, cfg_tvalid, iq_tready, i_out, q_out,
    input  cfg_tready, iq_tvalid, i_in, q_in
  );

  modport slave (
    input  cfg_tdata, cfg_tvalid, iq_tready, i_out, q_out,
    output cfg_tready, iq_tvalid, i_in, q_in
  );
endinterface

// File: rtl/duc_burst_ctrl.sv
// Transmit burst sequencer for the DUC: DDS config, settle, ramped I/Q
// streaming with zero-fill on underrun, then a zero flush before done.
module duc_burst_ctrl #(
  parameter int RAMP_LOG2  = 4,
  parameter int SETTLE_CYC = 8,
  parameter int FLUSH_CYC  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic          [15:0] burst_len,
  input  logic          [31:0] pinc,
  duc_burst_ctrl_if.master     bus,
  output logic                 tx_en,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 underrun
);

  localparam int DATA_W   = 16;
  localparam int RAMP_LEN = 1 << RAMP_LOG2;
  localparam int G_W      = RAMP_LOG2 + 2;
  localparam int P_W      = DATA_W + RAMP_LOG2 + 2;

  typedef enum logic [2:0] {
    IDLE, CFG, SETTLE, RAMP_UP, DATA, RAMP_DOWN, FLUSH
  } state_t;

  state_t                  state, state_nxt;
  logic           [15:0]   cnt, cnt_nxt;
  logic           [15:0]   len_q;
  logic           [31:0]   pinc_q;
  logic           [15:0]   data_len;
  logic                    streaming;
  logic                    start_ok;
  logic signed [G_W-1:0]   gain;

  // Arithmetic shift truncates toward minus infinity; g = RAMP_LEN is exact.
  function automatic logic signed [DATA_W-1:0] scale(
    input logic signed [DATA_W-1:0] x,
    input logic signed [G_W-1:0]    g
  );
    logic signed [P_W-1:0] p;
    p = P_W'(x) * P_W'(g);
    p = p >>> RAMP_LOG2;
    return p[DATA_W-1:0];
  endfunction

  assign data_len      = len_q - 16'(2 * RAMP_LEN);
  assign start_ok      = start && ({1'b0, burst_len} >= 17'(2 * RAMP_LEN));
  assign busy          = (state != IDLE);
  assign bus.cfg_tdata = pinc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt + 16'd1;
    streaming      = 1'b0;
    gain           = '0;
    bus.cfg_tvalid = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start_ok) state_nxt = CFG;
      end
      CFG: begin
        cnt_nxt        = '0;
        bus.cfg_tvalid = 1'b1;
        if (abort)               state_nxt = IDLE;
        else if (bus.cfg_tready) state_nxt = (SETTLE_CYC == 0) ? RAMP_UP : SETTLE;
      end
      SETTLE: begin
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == 16'(SETTLE_CYC - 1)) begin
          state_nxt = RAMP_UP;
          cnt_nxt   = '0;
        end
      end
      RAMP_UP: begin
        streaming = 1'b1;
        gain      = signed'(cnt[G_W-1:0] + G_W'(1));
        if (cnt == 16'(RAMP_LEN - 1)) begin
          state_nxt = (data_len == 16'd0) ? RAMP_DOWN : DATA;
          cnt_nxt   = '0;
        end
      end
      DATA: begin
        streaming = 1'b1;
        gain      = G_W'(RAMP_LEN);
        if (cnt == data_len - 16'd1) begin
          state_nxt = RAMP_DOWN;
          cnt_nxt   = '0;
        end
      end
      RAMP_DOWN: begin
        streaming = 1'b1;
        gain      = signed'(G_W'(RAMP_LEN - 1) - cnt[G_W-1:0]);
        if (cnt == 16'(RAMP_LEN - 1)) begin
          state_nxt = FLUSH;
          cnt_nxt   = '0;
        end
      end
      FLUSH: begin
        if (cnt == 16'(FLUSH_CYC)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // An abort slot is not consumed: it already emits the first flush zero.
    if (streaming && abort) begin
      state_nxt = FLUSH;
      cnt_nxt   = '0;
    end
  end

  assign bus.iq_tready = streaming && !abort;

  // Output stage: registered samples and status, one cycle after the slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q     <= '0;
      pinc_q    <= '0;
      bus.i_out <= '0;
      bus.q_out <= '0;
      tx_en     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      err   <= (state == IDLE) && start && !start_ok;
      done  <= (state == FLUSH) && (cnt == 16'(FLUSH_CYC));
      tx_en <= streaming || ((state == FLUSH) && (cnt < 16'(FLUSH_CYC)));
      if ((state == IDLE) && start_ok) begin
        len_q    <= burst_len;
        pinc_q   <= pinc;
        underrun <= 1'b0;
      end
      if (bus.iq_tready && !bus.iq_tvalid) underrun <= 1'b1;
      if (bus.iq_tready && bus.iq_tvalid) begin
        bus.i_out <= scale(bus.i_in, gain);
        bus.q_out <= scale(bus.q_in, gain);
      end else begin
        bus.i_out <= '0;
        bus.q_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_duc_burst_ctrl.sv
// Directed-plus-random bench for duc_burst_ctrl against a slot-level gain model.
module tb_duc_burst_ctrl;
  localparam int RAMP_LOG2 = 2;
  localparam int SETTLE    = 8;
  localparam int FLUSH     = 4;
  localparam int R         = 1 << RAMP_LOG2;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [15:0] burst_len;
  logic [31:0] pinc;
  logic        tx_en, busy, done, err, underrun;
  int          n_cmp = 0;
  int          n_err = 0;

  duc_burst_ctrl_if bus();

  duc_burst_ctrl #(.RAMP_LOG2(RAMP_LOG2), .SETTLE_CYC(SETTLE), .FLUSH_CYC(FLUSH)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .burst_len(burst_len), .pinc(pinc), .bus(bus),
    .tx_en(tx_en), .busy(busy), .done(done), .err(err), .underrun(underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Gain per slot from the burst shape; floor division of x*g by R.
  function automatic int ref_out(input int x, input int k, input int len);
    int g, p, q;
    if (k < R)              g = k + 1;
    else if (k >= len - R)  g = len - 1 - k;
    else                    g = R;
    p = x * g;
    q = p / R;
    if ((p % R) != 0 && p < 0) q = q - 1;
    return q;
  endfunction

  function automatic int pick(input int mode, input int k);
    if (mode == 1) return 1000;
    if (mode == 2) return (k == 0) ? -1 : -32768;
    return int'($urandom_range(65535)) - 32768;
  endfunction

  task automatic burst(input int len, input int mode, input int stall, input int hole,
                       input int abort_k, input int reset_k, input bit abort_at_start);
    logic [31:0] p;
    int xi, xq, ntr, e;
    bit ab, exp_ur;
    p = (mode == 1) ? 32'h1000_0000 : $urandom();
    start = 1'b1; abort = abort_at_start; burst_len = 16'(len); pinc = p;
    bus.cfg_tready = 1'b0;
    step();
    start = 1'b0; abort = 1'b0;
    chk("underrun_clr_on_start", 32'(underrun), 32'(0));
    chk("busy_cfg", 32'(busy), 32'(1));
    for (int w = 0; w <= stall; w++) begin
      chk("cfg_tvalid_held", 32'(bus.cfg_tvalid), 32'(1));
      chk("cfg_tdata_held", bus.cfg_tdata, p);
      bus.cfg_tready = (w == stall);
      step();
    end
    bus.cfg_tready = 1'b0;
    chk("cfg_tvalid_drop", 32'(bus.cfg_tvalid), 32'(0));
    for (int s = 0; s < SETTLE; s++) begin
      chk("settle_tready", 32'(bus.iq_tready), 32'(0));
      chk("settle_tx_en", 32'(tx_en), 32'(0));
      chk("settle_busy", 32'(busy), 32'(1));
      start = (s == 0);
      burst_len = 16'd3;
      step();
    end
    start = 1'b0;
    ntr = 0; exp_ur = 1'b0;
    for (int k = 0; k < len; k++) begin
      ab = (k == abort_k);
      abort = ab;
      bus.iq_tvalid = (k != hole);
      xi = pick(mode, k); xq = pick(mode, k + 1);
      bus.i_in = 16'(xi); bus.q_in = 16'(xq);
      #1;
      chk("iq_tready", 32'(bus.iq_tready), 32'(!ab));
      ntr += int'(bus.iq_tready);
      if (!ab && k == hole) exp_ur = 1'b1;
      if (k == reset_k) begin
        reset = 1'b1;
        step();
        reset = 1'b0; bus.iq_tvalid = 1'b0;
        chk("rst_i_out", 32'(bus.i_out), 32'(0));
        chk("rst_q_out", 32'(bus.q_out), 32'(0));
        chk("rst_tx_en", 32'(tx_en), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_underrun", 32'(underrun), 32'(0));
        chk("rst_tready", 32'(bus.iq_tready), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        return;
      end
      step();
      abort = 1'b0;
      e = (ab || k == hole) ? 0 : ref_out(xi, k, len);
      chk("i_out", 32'(bus.i_out), 32'(e));
      e = (ab || k == hole) ? 0 : ref_out(xq, k, len);
      chk("q_out", 32'(bus.q_out), 32'(e));
      chk("stream_tx_en", 32'(tx_en), 32'(1));
      if (ab) break;
    end
    bus.iq_tvalid = 1'b0;
    chk("slot_count", 32'(ntr), 32'((abort_k >= 0) ? abort_k : len));
    for (int f = 0; f < FLUSH; f++) begin
      step();
      chk("flush_i_out", 32'(bus.i_out), 32'(0));
      chk("flush_q_out", 32'(bus.q_out), 32'(0));
      chk("flush_tx_en", 32'(tx_en), 32'(1));
      chk("flush_done", 32'(done), 32'(0));
      chk("flush_tready", 32'(bus.iq_tready), 32'(0));
    end
    step();
    chk("done_pulse", 32'(done), 32'(1));
    chk("done_tx_en", 32'(tx_en), 32'(0));
    chk("done_busy", 32'(busy), 32'(0));
    chk("underrun_sticky", 32'(underrun), 32'(exp_ur));
    step();
    chk("done_one_cycle", 32'(done), 32'(0));
  endtask

  initial begin
    int len, hole;
    reset = 1'b1; start = 1'b0; abort = 1'b0; burst_len = '0; pinc = '0;
    bus.cfg_tready = 1'b0; bus.iq_tvalid = 1'b0; bus.i_in = '0; bus.q_in = '0;
    repeat (3) step();
    chk("reset_cfg_tdata", bus.cfg_tdata, 32'(0));
    chk("reset_cfg_tvalid", 32'(bus.cfg_tvalid), 32'(0));
    chk("reset_i_out", 32'(bus.i_out), 32'(0));
    chk("reset_q_out", 32'(bus.q_out), 32'(0));
    chk("reset_tready", 32'(bus.iq_tready), 32'(0));
    chk("reset_tx_en", 32'(tx_en), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_err", 32'(err), 32'(0));
    chk("reset_underrun", 32'(underrun), 32'(0));
    reset = 1'b0;
    step();

    // Rejected start: too short for two ramps.
    start = 1'b1; burst_len = 16'd7; pinc = 32'hdead_beef;
    step();
    start = 1'b0;
    chk("reject_err", 32'(err), 32'(1));
    chk("reject_busy", 32'(busy), 32'(0));
    chk("reject_cfg_tvalid", 32'(bus.cfg_tvalid), 32'(0));
    step();
    chk("reject_err_once", 32'(err), 32'(0));
    chk("reject_busy_after", 32'(busy), 32'(0));

    burst(10, 1, 0, -1, -1, -1, 1'b0);      // nominal constant 1000
    burst(12, 0, 5, -1, -1, -1, 1'b0);      // config backpressure
    burst(9, 2, 0, -1, -1, -1, 1'b0);       // negative truncation / full-scale
    burst(8, 0, 0, -1, -1, -1, 1'b0);       // no DATA slots
    burst(12, 0, 0, R + 2, -1, -1, 1'b0);   // underrun on 3rd DATA slot
    burst(10, 0, 0, -1, -1, -1, 1'b1);      // start+abort in IDLE; clears underrun
    burst(14, 0, 0, -1, R + 1, -1, 1'b0);   // abort in 2nd DATA slot

    // Abort while settling.
    start = 1'b1; burst_len = 16'd10; pinc = 32'h1234_5678;
    step();
    start = 1'b0; bus.cfg_tready = 1'b1;
    step();
    bus.cfg_tready = 1'b0;
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("settle_abort_busy", 32'(busy), 32'(0));
    chk("settle_abort_cfg_tvalid", 32'(bus.cfg_tvalid), 32'(0));
    for (int i = 0; i < 12; i++) begin
      step();
      chk("settle_abort_no_done", 32'(done), 32'(0));
      chk("settle_abort_tx_en", 32'(tx_en), 32'(0));
    end

    burst(10, 0, 0, 2, -1, 7, 1'b0);        // reset in 2nd RAMP_DOWN slot

    for (int n = 0; n < 5; n++) begin
      len  = int'($urandom_range(30, 8));
      hole = ($urandom_range(1) == 1) ? int'($urandom_range(len - 1)) : -1;
      burst(len, 0, int'($urandom_range(3)), hole, -1, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
